or_pattern_sequencer: RTL

- Self-contained stimulus sequencer and gated-OR checker.
- Walks a DEPTH-entry enable pattern. At each step it drives the step index onto a WIDTH-bit data bus and drives a CH-bit enable bus to all-ones or all-zeros.
- Produces a registered gated result and a run-wide OR accumulation.
- Parametrised successor of the fixed 4-bit/3-enable OR-gate stimulus flow. Used as an on-chip BIST-style driver in front of gate-level blocks.

---
 rtl/or_pattern_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/or_pattern_sequencer.sv
// or_pattern_sequencer: walks a latched DEPTH-entry enable pattern, holding
// each step for HOLD cycles. Each step puts its index on a_out and a solid
// enable word on en_out. It also produces a registered gated result (b_out)
// and the OR of every b_out value in the run (acc_out).
//
// Handshake: start is taken only in IDLE and only when stop is low on the
// same edge. stop at any RUN edge ends the run on that edge. done and
// aborted are one-cycle registered pulses that mark the first IDLE cycle
// after a normal or an aborted run. busy is high exactly while the FSM is
// in RUN, so it also serves as the observable FSM state.
module or_pattern_sequencer #(
    parameter int WIDTH = 4,
    parameter int CH    = 3,
    parameter int DEPTH = 4,
    parameter int HOLD  = 5,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DEPTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [IW-1:0]    step_idx,
    output logic [WIDTH-1:0] a_out,
    output logic [CH-1:0]    en_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] acc_out
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IW-1:0] LAST_STEP = IW'(DEPTH - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT            state;
    logic [DEPTH-1:0] patQ;
    logic [HW-1:0]    holdCnt;
    logic [IW-1:0]    nextStep;

    // Index of the step that follows the current one; it is only consumed
    // when the current step is not the last, so it never leaves 0..DEPTH-1.
    always_comb begin
        nextStep = step_idx + IW'(1);
    end

    // Sequencer FSM with every output registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            patQ     <= '0;
            holdCnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            step_idx <= '0;
            a_out    <= '0;
            en_out   <= '0;
            b_out    <= '0;
            acc_out  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Gated result: one cycle behind a_out/en_out, also in IDLE.
            b_out   <= (|en_out) ? a_out : '0;

            case (state)
                IDLE: begin
                    // The cycle after a normal finish folds in the final b_out.
                    if (done) begin
                        acc_out <= acc_out | b_out;
                    end
                    if (start && !stop) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        patQ     <= pattern;
                        holdCnt  <= '0;
                        step_idx <= '0;
                        a_out    <= '0;
                        en_out   <= {CH{pattern[0]}};
                        acc_out  <= '0;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Abort freezes a_out, step_idx and acc_out as they are.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        en_out  <= '0;
                    end else begin
                        acc_out <= acc_out | b_out;
                        if (holdCnt == LAST_HOLD) begin
                            holdCnt <= '0;
                            if (step_idx == LAST_STEP) begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                en_out <= '0;
                            end else begin
                                step_idx <= nextStep;
                                a_out    <= a_out + WIDTH'(1);
                                en_out   <= {CH{patQ[nextStep]}};
                            end
                        end else begin
                            holdCnt <= holdCnt + HW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
